// File: rtl/pattern_frame_loader.sv
// pattern_frame_loader
// Assembles {address, 10-bit timestamp, 8-bit pattern} records from a UART
// byte stream and hands each one to the pattern memory as a single-cycle
// write strobe.
//
// Frame: HEADER, {addr[1:0], 4 reserved bits, ts[9:8]}, ts[7:0], pattern
//        [, checksum = B1 ^ B2 ^ B3]
//
// Build option: define CHKSUM_EN to require and check the trailing XOR
// checksum byte. Without it, frames are four bytes long and an inter-byte
// timeout is the only error source.
module pattern_frame_loader #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic        CLOCK50M,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        write,
  output logic [1:0]  address,
  output logic [17:0] pattern_with_timestamp,
  output logic        busy,
  output logic        err_pulse,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Each working state names the frame byte it is waiting for:
  // HDR_OK waits for B1 (address and timestamp high bits), TS_LO for B2,
  // PAT for B3 and CSUM for the checksum byte.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_OK = 3'd1,
    TS_LO  = 3'd2,
    PAT    = 3'd3,
    CSUM   = 3'd4
  } state_t;

  state_t         state;
  logic [CW-1:0]  tmo_cnt;
  logic [1:0]     addr_sh;
  logic [1:0]     ts_hi_sh;
  logic [7:0]     ts_lo_sh;
`ifdef CHKSUM_EN
  logic [7:0]     pat_sh;
  logic [7:0]     csum_acc;
`endif

  // Frame FSM, shadow capture, inter-byte timeout and all registered outputs.
  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      state                  <= IDLE;
      tmo_cnt                <= '0;
      addr_sh                <= 2'd0;
      ts_hi_sh               <= 2'd0;
      ts_lo_sh               <= 8'd0;
`ifdef CHKSUM_EN
      pat_sh                 <= 8'd0;
      csum_acc               <= 8'd0;
`endif
      write                  <= 1'b0;
      address                <= 2'd0;
      pattern_with_timestamp <= 18'd0;
      busy                   <= 1'b0;
      err_pulse              <= 1'b0;
      frame_count            <= 16'd0;
      err_count              <= 8'd0;
    end else begin
      write     <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          // Anything other than the header is line noise between frames.
          if (rx_valid && (rx_data == HEADER)) begin
            state <= HDR_OK;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        default: begin
          if (rx_valid) begin
            // A byte always beats a coincident timeout expiry.
            tmo_cnt <= '0;
            case (state)
              HDR_OK: begin
                addr_sh  <= rx_data[7:6];
                ts_hi_sh <= rx_data[1:0];
`ifdef CHKSUM_EN
                csum_acc <= rx_data;
`endif
                state    <= TS_LO;
              end
              TS_LO: begin
                ts_lo_sh <= rx_data;
`ifdef CHKSUM_EN
                csum_acc <= csum_acc ^ rx_data;
`endif
                state    <= PAT;
              end
              PAT: begin
`ifdef CHKSUM_EN
                pat_sh   <= rx_data;
                csum_acc <= csum_acc ^ rx_data;
                state    <= CSUM;
`else
                write                  <= 1'b1;
                address                <= addr_sh;
                pattern_with_timestamp <= {ts_hi_sh, ts_lo_sh, rx_data};
                frame_count            <= frame_count + 16'd1;
                state                  <= IDLE;
                busy                   <= 1'b0;
`endif
              end
`ifdef CHKSUM_EN
              CSUM: begin
                state <= IDLE;
                busy  <= 1'b0;
                if (rx_data == csum_acc) begin
                  write                  <= 1'b1;
                  address                <= addr_sh;
                  pattern_with_timestamp <= {ts_hi_sh, ts_lo_sh, pat_sh};
                  frame_count            <= frame_count + 16'd1;
                end else begin
                  err_pulse <= 1'b1;
                  if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                  end else begin
                    err_count <= err_count;
                  end
                end
              end
`endif
              default: begin
                // Unreachable encodings recover to IDLE.
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            // Sender went quiet mid-frame: drop the partial frame.
            state     <= IDLE;
            busy      <= 1'b0;
            tmo_cnt   <= '0;
            err_pulse <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end else begin
              err_count <= err_count;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_frame_loader.sv
// Self-checking bench for pattern_frame_loader: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against a frame-level reference model.
module tb_pattern_frame_loader;

  localparam logic [7:0] HEADER = 8'hA5;
  localparam int         TMO    = 8;
`ifdef CHKSUM_EN
  localparam int FLEN = 5;
  localparam int EC_AFTER_TO = 2;
`else
  localparam int FLEN = 4;
  localparam int EC_AFTER_TO = 1;
`endif

  logic        CLOCK50M = 1'b0;
  logic        reset    = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        write;
  logic [1:0]  address;
  logic [17:0] pattern_with_timestamp;
  logic        busy;
  logic        err_pulse;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected outputs after the most recent edge.
  logic        m_write = 1'b0;
  logic        m_err   = 1'b0;
  logic [1:0]  m_addr  = 2'd0;
  logic [17:0] m_pwt   = 18'd0;
  logic [15:0] m_fc    = 16'd0;
  logic [7:0]  m_ec    = 8'd0;
  logic        m_in    = 1'b0;
  int          m_gap   = 0;
  logic [7:0]  m_q[$];

  pattern_frame_loader #(.HEADER(HEADER), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK50M(CLOCK50M), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .write(write), .address(address), .pattern_with_timestamp(pattern_with_timestamp),
    .busy(busy), .err_pulse(err_pulse), .frame_count(frame_count), .err_count(err_count)
  );

  always #5 CLOCK50M = ~CLOCK50M;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic m_error();
    m_in  = 1'b0;
    m_err = 1'b1;
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
  endtask

  // Frame-level model: collect the bytes following a header, then judge the
  // whole frame once it is complete; silence of TMO cycles abandons it.
  task automatic model_edge();
    logic ok;
    m_write = 1'b0;
    m_err   = 1'b0;
    if (reset) begin
      m_addr = 2'd0; m_pwt = 18'd0; m_fc = 16'd0; m_ec = 8'd0;
      m_in = 1'b0; m_gap = 0; m_q.delete();
    end else if (!m_in) begin
      if (rx_valid && rx_data == HEADER) begin
        m_in = 1'b1; m_gap = 0; m_q.delete();
      end
    end else if (rx_valid) begin
      m_q.push_back(rx_data);
      m_gap = 0;
      if (m_q.size() == FLEN - 1) begin
        m_in = 1'b0;
`ifdef CHKSUM_EN
        ok = ((m_q[0] ^ m_q[1] ^ m_q[2]) == m_q[3]);
`else
        ok = 1'b1;
`endif
        if (ok) begin
          m_write = 1'b1;
          m_addr  = m_q[0][7:6];
          m_pwt   = {m_q[0][1:0], m_q[1], m_q[2]};
          m_fc    = m_fc + 16'd1;
        end else begin
          m_error();
        end
      end
    end else begin
      m_gap++;
      if (m_gap == TMO) m_error();
    end
  endtask

  // One clock cycle of stimulus; the model advances on the same edge.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge CLOCK50M);
    model_edge();
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 8'h00);
    reset = 1'b0;
  endtask

  // Sends a whole frame; good_cs selects a correct or corrupted checksum.
  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic good_cs);
    logic [7:0] cs;
    cs = b1 ^ b2 ^ b3;
    step(1'b1, HEADER);
    step(1'b1, b1);
    step(1'b1, b2);
    step(1'b1, b3);
`ifdef CHKSUM_EN
    step(1'b1, good_cs ? cs : ~cs);
`else
    if (!good_cs) step(1'b1, ~cs);
`endif
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge CLOCK50M) begin
    chk("write", {31'd0, write}, {31'd0, m_write});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
    chk("busy", {31'd0, busy}, {31'd0, m_in});
    chk("address", {30'd0, address}, {30'd0, m_addr});
    chk("pattern_with_timestamp", {14'd0, pattern_with_timestamp}, {14'd0, m_pwt});
    chk("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
    chk("err_count", {24'd0, err_count}, {24'd0, m_ec});
  end

  initial begin
    logic [7:0] b1, b2, b3;
    int act;
    int g;

    // Reset state.
    step(1'b0, 8'h00);
    do_reset();
    chk("lit_reset_fc", {16'd0, frame_count}, 32'd0);
    chk("lit_reset_busy", {31'd0, busy}, 32'd0);
    chk("lit_reset_pwt", {14'd0, pattern_with_timestamp}, 32'd0);

    // Basic frame commits one cycle after its last byte.
    send_frame(8'h00, 8'h2A, 8'h5C, 1'b1);
    chk("lit_f1_write", {31'd0, write}, 32'd1);
    chk("lit_f1_pwt", {14'd0, pattern_with_timestamp}, 32'h02A5C);
    chk("lit_f1_fc", {16'd0, frame_count}, 32'd1);
    chk("lit_f1_err", {31'd0, err_pulse}, 32'd0);

`ifdef CHKSUM_EN
    // Bad checksum: no write, error counted, outputs held.
    send_frame(8'h00, 8'h2A, 8'h5C, 1'b0);
    chk("lit_cs_err", {31'd0, err_pulse}, 32'd1);
    chk("lit_cs_write", {31'd0, write}, 32'd0);
    chk("lit_cs_ec", {24'd0, err_count}, 32'd1);
    chk("lit_cs_pwt", {14'd0, pattern_with_timestamp}, 32'h02A5C);
`endif

    // Inter-byte timeout: error exactly TMO cycles after the last byte.
    step(1'b1, HEADER);
    step(1'b1, 8'hC3);
    step(1'b1, 8'hFF);
    if (FLEN == 5) step(1'b1, 8'h81);
    idle(TMO - 1);
    chk("lit_to_early_busy", {31'd0, busy}, 32'd1);
    chk("lit_to_early_err", {31'd0, err_pulse}, 32'd0);
    idle(1);
    chk("lit_to_err", {31'd0, err_pulse}, 32'd1);
    chk("lit_to_busy", {31'd0, busy}, 32'd0);
    chk("lit_to_ec", {24'd0, err_count}, EC_AFTER_TO);
    send_frame(8'hC3, 8'hFF, 8'h81, 1'b1);
    chk("lit_f3_addr", {30'd0, address}, 32'd3);
    chk("lit_f3_pwt", {14'd0, pattern_with_timestamp}, 32'h3FF81);

    // Noise in IDLE is ignored; a header value inside a frame is data.
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    chk("lit_noise_busy", {31'd0, busy}, 32'd0);
    chk("lit_noise_err", {31'd0, err_pulse}, 32'd0);
    send_frame(8'h00, 8'hA5, 8'hA5, 1'b1);
    chk("lit_hdrdata_pwt", {14'd0, pattern_with_timestamp}, 32'h0A5A5);

    // Back-to-back frames, second header in the first commit cycle.
    do_reset();
    send_frame(8'h40, 8'h12, 8'h34, 1'b1);
    send_frame(8'h81, 8'h56, 8'h78, 1'b1);
    chk("lit_b2b_write", {31'd0, write}, 32'd1);
    chk("lit_b2b_fc", {16'd0, frame_count}, 32'd2);
    chk("lit_b2b_pwt", {14'd0, pattern_with_timestamp}, 32'h15678);

    // Reset mid-frame discards it; later frames still commit.
    step(1'b1, HEADER);
    step(1'b1, 8'hC1);
    step(1'b1, 8'h99);
    do_reset();
    chk("lit_mid_rst_fc", {16'd0, frame_count}, 32'd0);
    chk("lit_mid_rst_addr", {30'd0, address}, 32'd0);
    step(1'b1, 8'h42);
    chk("lit_mid_rst_write", {31'd0, write}, 32'd0);
    send_frame(8'h80, 8'h01, 8'h02, 1'b1);
    chk("lit_after_rst_addr", {30'd0, address}, 32'd2);
    chk("lit_after_rst_fc", {16'd0, frame_count}, 32'd1);

    // err_count saturation.
    for (int i = 0; i < 257; i++) begin
`ifdef CHKSUM_EN
      send_frame(i[7:0], 8'h3C, 8'h5A, 1'b0);
`else
      step(1'b1, HEADER);
      idle(TMO);
`endif
    end
    chk("lit_sat_ec", {24'd0, err_count}, 32'hFF);
    chk("lit_sat_err", {31'd0, err_pulse}, 32'd1);

    // Randomized traffic: frames with varied gaps (some at/over the
    // timeout), corrupt checksums, noise bytes, silence and resets.
    for (int it = 0; it < 400; it++) begin
      act = $urandom_range(0, 19);
      if (act == 0) begin
        do_reset();
      end else if (act <= 3) begin
        step(1'b1, ($urandom_range(0, 3) == 0) ? HEADER : 8'($urandom));
      end else if (act == 4) begin
        idle($urandom_range(0, 12));
      end else begin
        b1 = 8'($urandom);
        b2 = ($urandom_range(0, 4) == 0) ? HEADER : 8'($urandom);
        b3 = ($urandom_range(0, 4) == 0) ? HEADER : 8'($urandom);
        step(1'b1, HEADER);
        for (int k = 0; k < FLEN - 1; k++) begin
          g = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 1)
                                          : $urandom_range(0, 1);
          idle(g);
          case (k)
            0: step(1'b1, b1);
            1: step(1'b1, b2);
            2: step(1'b1, b3);
            default: step(1'b1, (act == 19) ? ~(b1 ^ b2 ^ b3) : (b1 ^ b2 ^ b3));
          endcase
        end
      end
    end
    idle(TMO + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
